// File: rtl/req_arbiter_8.sv
// Eight-way request arbiter with a registered one-hot grant, selectable fixed-priority or
// round-robin winner selection, and an optional hold-time limit that forces a release.
module req_arbiter_8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       rr_mode,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
   logic [2:0]       last, last_next;
   logic [7:0]       gnt_next;
   logic [2:0]       idx_next;
   logic             timeout_next;
   logic [2:0]       fixed_idx;
   logic [2:0]       rr_idx;
   logic [2:0]       rr_cand;
   logic [2:0]       win_idx;
   logic             hold_limit;

   // Fixed priority: the highest set request index wins.
   always_comb begin
      fixed_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) fixed_idx = 3'(i);
      end
   end

   // Round-robin: scan from last-1 downward with wrap, ending at last itself. Iterating the
   // farthest candidate first lets the nearest one (last-1) overwrite and therefore win.
   always_comb begin
      rr_idx  = '0;
      rr_cand = '0;
      for (int k = 8; k >= 1; k--) begin
         rr_cand = last - 3'(k);
         if (req[rr_cand]) rr_idx = rr_cand;
      end
   end

   assign win_idx    = rr_mode ? rr_idx : fixed_idx;
   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   assign gnt_valid  = |gnt;

   // Next-state logic. Owner release and enable loss are tested before the hold limit, so
   // either of them suppresses the timeout pulse when they coincide with it.
   always_comb begin
      state_next    = state;
      gnt_next      = gnt;
      idx_next      = gnt_idx;
      timeout_next  = 1'b0;
      hold_cnt_next = hold_cnt;
      last_next     = last;
      case (state)
         IDLE: begin
            gnt_next      = '0;
            idx_next      = '0;
            hold_cnt_next = '0;
            if (enable && (|req)) begin
               state_next = GRANT;
               gnt_next   = 8'd1 << win_idx;
               idx_next   = win_idx;
               last_next  = win_idx;
            end
         end
         GRANT: begin
            if (!req[gnt_idx] || !enable) begin
               state_next    = IDLE;
               gnt_next      = '0;
               idx_next      = '0;
               hold_cnt_next = '0;
            end else if (hold_limit) begin
               state_next    = IDLE;
               gnt_next      = '0;
               idx_next      = '0;
               hold_cnt_next = '0;
               timeout_next  = 1'b1;
            end else if (hold_cnt != '1) begin
               hold_cnt_next = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_next    = IDLE;
            gnt_next      = '0;
            idx_next      = '0;
            hold_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         last     <= '0;
      end else begin
         state    <= state_next;
         gnt      <= gnt_next;
         gnt_idx  <= idx_next;
         timeout  <= timeout_next;
         hold_cnt <= hold_cnt_next;
         last     <= last_next;
      end
   end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Scoreboard bench for req_arbiter_8: stimulus queues the expected grants (index, length,
// timeout flag) and a negedge monitor pops and checks each grant the DUT presents.
module tb_req_arbiter_8;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       rr_mode;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   typedef struct {
      logic [2:0] idx;
      int         len;
      logic       to;
   } grant_t;

   grant_t exp_q[$];
   int     checks = 0;
   int     errors = 0;

   req_arbiter_8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .rr_mode  (rr_mode),
      .req      (req),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_grant(input logic [2:0] idx, input int len, input logic to);
      grant_t g;
      g.idx = idx;
      g.len = len;
      g.to  = to;
      exp_q.push_back(g);
   endtask

   // Monitor: a rising gnt_valid pops the next expected grant; its falling edge checks
   // the held length and whether the idle cycle carries the timeout pulse.
   logic        active  = 1'b0;
   grant_t      cur;
   int          len_cnt = 0;
   logic [31:0] one     = 32'd1;

   always @(negedge clk) begin
      if (gnt_valid) begin
         if (!active) begin
            check_output("grant_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else begin
               cur.idx = 3'd0;
               cur.len = 0;
               cur.to  = 1'b0;
            end
            active  = 1'b1;
            len_cnt = 0;
         end
         len_cnt++;
         check_output("gnt_idx", 32'(gnt_idx), 32'(cur.idx));
         check_output("gnt", 32'(gnt), one << cur.idx);
         check_output("timeout_in_grant", 32'(timeout), 32'd0);
      end else begin
         check_output("timeout", 32'(timeout), 32'(active && cur.to));
         if (active) check_output("hold_len", 32'(len_cnt), 32'(cur.len));
         check_output("gnt_idle", 32'(gnt), 32'd0);
         check_output("idx_idle", 32'(gnt_idx), 32'd0);
         active = 1'b0;
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: run still active at %0t, expected to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      rr_mode = 1'b0;
      req     = 8'hFF;

      // Reset holds everything low even with every request asserted.
      apply_step(3);
      check_output("rst_gnt", 32'(gnt), 32'd0);
      check_output("rst_idx", 32'(gnt_idx), 32'd0);
      check_output("rst_valid", 32'(gnt_valid), 32'd0);
      check_output("rst_timeout", 32'(timeout), 32'd0);

      expect_grant(3'd7, 2, 1'b0);
      reset = 1'b0;
      apply_step(1);
      check_output("first_gnt", 32'(gnt), 32'h80);
      check_output("first_idx", 32'(gnt_idx), 32'd7);
      check_output("first_valid", 32'(gnt_valid), 32'd1);
      apply_step(1);
      req = 8'h00;
      apply_step(2);

      // Fixed priority 4 over 2, release, then 2 runs into the hold limit.
      expect_grant(3'd4, 2, 1'b0);
      expect_grant(3'd2, 4, 1'b1);
      req = 8'b0001_0100;
      apply_step(2);
      req = 8'b0000_0100;
      apply_step(6);
      req = 8'h00;
      apply_step(1);

      reset = 1'b1;
      apply_step(1);
      reset = 1'b0;

      // Round-robin sweep with everyone requesting: 7 down to 0, then wrap to 7.
      rr_mode = 1'b1;
      req     = 8'hFF;
      for (int i = 7; i >= 0; i--) expect_grant(3'(i), 4, 1'b1);
      expect_grant(3'd7, 4, 1'b1);
      apply_step(45);
      req = 8'h00;
      apply_step(2);

      // Enable loss ends the grant without a timeout; no grant while disabled.
      rr_mode = 1'b0;
      expect_grant(3'd3, 2, 1'b0);
      req = 8'b0000_1000;
      apply_step(2);
      enable = 1'b0;
      req    = 8'h0F;
      apply_step(4);
      check_output("disabled_valid", 32'(gnt_valid), 32'd0);
      req    = 8'h00;
      enable = 1'b1;
      apply_step(2);

      // RR from last=3 picks 0; reset mid-grant restarts the search at 7 so 5 wins next.
      rr_mode = 1'b1;
      expect_grant(3'd0, 1, 1'b0);
      expect_grant(3'd5, 4, 1'b0);
      expect_grant(3'd1, 2, 1'b0);
      req = 8'b0010_0001;
      apply_step(2);
      reset = 1'b1;
      #1;
      check_output("async_rst_gnt", 32'(gnt), 32'd0);
      check_output("async_rst_valid", 32'(gnt_valid), 32'd0);
      check_output("async_rst_idx", 32'(gnt_idx), 32'd0);
      #1;
      reset = 1'b0;
      apply_step(1);
      req = 8'b0010_0011;
      apply_step(3);
      // Owner drops on the same edge the hold limit would fire: release wins, no pulse.
      req = 8'b0000_0011;
      apply_step(3);
      req = 8'h00;
      apply_step(3);

      check_output("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
